// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// datapath select codes and ALU operation codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields / flags in, datapath control strobes and selects out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields to an ALU operation code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB:  ALUControl = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // op5 separates R-type sub from addi, which has no sub form
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default:    ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RISC-V datapath; ALU op decode lives
// in alu_decoder, PC enable and immediate format are derived here.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master ctrl
);

  state_t     state_q, state_d, out_st;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src, take;
  logic [1:0] alu_op, result_src, src_a, src_b;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Under reset the outputs decode as FETCH; enables are masked below.
  always_comb begin
    out_st     = reset ? state_q : S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    case (out_st)
      S_FETCH: begin
        ir_write = 1'b1; pc_update = 1'b1;
        src_b = SRCB_FOUR; result_src = RES_ALURESULT;
      end
      S_DECODE:   begin src_a = SRCA_OLDPC; src_b = SRCB_IMM; end
      S_MEMADR:   begin src_a = SRCA_RD1;   src_b = SRCB_IMM; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      S_EXECUTER: begin src_a = SRCA_RD1; src_b = SRCB_RD2; alu_op = ALUOP_FUNC; end
      S_EXECUTEI: begin src_a = SRCA_RD1; src_b = SRCB_IMM; alu_op = ALUOP_FUNC; end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL:      begin src_a = SRCA_OLDPC; src_b = SRCB_FOUR; pc_update = 1'b1; end
      S_BEQ:      begin src_a = SRCA_RD1; src_b = SRCB_RD2; alu_op = ALUOP_SUB; branch = 1'b1; end
      default:    ;
    endcase
  end

  assign take = (BNE_EN && ctrl.funct3 == 3'b001) ? ~ctrl.Zero : ctrl.Zero;

  assign ctrl.PCWrite   = reset & (pc_update | (branch & take));
  assign ctrl.IRWrite   = reset & ir_write;
  assign ctrl.MemWrite  = reset & mem_write;
  assign ctrl.RegWrite  = reset & reg_write;
  assign ctrl.AdrSrc    = adr_src;
  assign ctrl.ResultSrc = result_src;
  assign ctrl.ALUSrcA   = src_a;
  assign ctrl.ALUSrcB   = src_b;
  assign ctrl.ImmSrc    = imm_src(ctrl.op);

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .funct3     (ctrl.funct3),
    .op5        (ctrl.op[5]),
    .funct7b5   (ctrl.funct7b5),
    .ALUControl (ctrl.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model checked every
// cycle, plus directed literal checks for each instruction class and reset.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.BNE_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
  } exp_t;

  // Cycles per instruction, including FETCH.
  function automatic int lat(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] func_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs from the instruction class and cycle index within it.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int step, input logic rst);
    exp_t e;
    e = '0;
    case (op)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    if (!rst || step == 0) begin
      e.sb = 2'b10; e.res = 2'b10; e.irw = rst; e.pcw = rst;
      return e;
    end
    if (step == 1) begin
      e.sa = 2'b01; e.sb = 2'b01;
      return e;
    end
    case (op)
      7'b0000011: begin
        if (step == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
        if (step == 3) e.adr = 1'b1;
        if (step == 4) begin e.res = 2'b01; e.regw = 1'b1; end
      end
      7'b0100011: begin
        if (step == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
        if (step == 3) begin e.adr = 1'b1; e.memw = 1'b1; end
      end
      7'b0110011, 7'b0010011: begin
        if (step == 2) begin
          e.sa = 2'b10; e.sb = (op == 7'b0010011) ? 2'b01 : 2'b00;
          e.alu = func_alu(op, f3, f7);
        end
        if (step == 3) e.regw = 1'b1;
      end
      7'b1101111: begin
        if (step == 2) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
        if (step == 3) e.regw = 1'b1;
      end
      7'b1100011: begin
        e.sa = 2'b10; e.alu = 3'b001;
        e.pcw = (f3 == 3'b001) ? ~z : z;
      end
      default: ;
    endcase
    return e;
  endfunction

  int   m_step  = 0;
  bit   m_valid = 1'b0;
  exp_t m_e;

  always @(posedge clk) begin
    if (!reset) begin
      m_step  <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_step <= (m_step == lat(bus.op) - 1) ? 0 : m_step + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      m_e = model(bus.op, bus.funct3, bus.funct7b5, bus.Zero, m_step, reset);
      chk("m_PCWrite",    bus.PCWrite,    m_e.pcw);
      chk("m_AdrSrc",     bus.AdrSrc,     m_e.adr);
      chk("m_IRWrite",    bus.IRWrite,    m_e.irw);
      chk("m_MemWrite",   bus.MemWrite,   m_e.memw);
      chk("m_RegWrite",   bus.RegWrite,   m_e.regw);
      chk("m_ResultSrc",  bus.ResultSrc,  m_e.res);
      chk("m_ALUSrcA",    bus.ALUSrcA,    m_e.sa);
      chk("m_ALUSrcB",    bus.ALUSrcB,    m_e.sb);
      chk("m_ImmSrc",     bus.ImmSrc,     m_e.imm);
      chk("m_ALUControl", bus.ALUControl, m_e.alu);
    end
  end

  task automatic next_cyc; @(posedge clk); #1; endtask
  task automatic at_mid;   @(negedge clk); #2; endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
  endtask

  task automatic en_zero(input string n);
    chk({n, "_pcw"},  bus.PCWrite,  1'b0);
    chk({n, "_irw"},  bus.IRWrite,  1'b0);
    chk({n, "_memw"}, bus.MemWrite, 1'b0);
    chk({n, "_regw"}, bus.RegWrite, 1'b0);
  endtask

  // Each test starts mid-FETCH and ends mid-FETCH of the following instruction.
  task automatic br_case(input string n, input logic [2:0] f3, input logic z, input logic exp_pcw);
    set_in(7'b1100011, f3, 1'b0, z);
    next_cyc; at_mid;
    next_cyc; at_mid;
    chk({n, "_pcw"}, bus.PCWrite,    exp_pcw);
    chk({n, "_alu"}, bus.ALUControl, 3'b001);
    chk({n, "_imm"}, bus.ImmSrc,     2'b10);
    next_cyc; at_mid;
    chk({n, "_fetch"}, bus.IRWrite, 1'b1);
  endtask

  task automatic alu_case(input string n, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] exp_alu);
    set_in(o, f3, f7, 1'b0);
    next_cyc; at_mid;
    next_cyc; at_mid;
    chk(n, bus.ALUControl, exp_alu);
    next_cyc; at_mid;
    next_cyc; at_mid;
  endtask

  initial begin
    reset = 1'b0;
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    next_cyc; at_mid; en_zero("rst_c1");
    chk("rst_c1_srcb", bus.ALUSrcB, 2'b10);
    next_cyc; at_mid; en_zero("rst_c2");
    next_cyc;
    reset = 1'b1;
    at_mid;
    chk("rel_irw",  bus.IRWrite,   1'b1);
    chk("rel_pcw",  bus.PCWrite,   1'b1);
    chk("rel_srcb", bus.ALUSrcB,   2'b10);
    chk("rel_res",  bus.ResultSrc, 2'b10);

    // Unknown opcode: FETCH, DECODE, FETCH
    set_in(7'b0000000, 3'b000, 1'b0, 1'b0);
    next_cyc; at_mid; en_zero("unk_dec");
    next_cyc; at_mid;
    chk("unk_fetch_irw", bus.IRWrite, 1'b1);

    // lw
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      next_cyc; at_mid;
      chk("lw_regw", bus.RegWrite, (c == 5));
      chk("lw_memw", bus.MemWrite, 1'b0);
      if (c == 5) chk("lw_res", bus.ResultSrc, 2'b01);
    end
    next_cyc; at_mid;
    chk("lw_end_irw", bus.IRWrite, 1'b1);

    // sw
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    #1 chk("sw_imm", bus.ImmSrc, 2'b01);
    for (int c = 2; c <= 4; c++) begin
      next_cyc; at_mid;
      chk("sw_memw", bus.MemWrite, (c == 4));
      chk("sw_adr",  bus.AdrSrc,   (c == 4));
      chk("sw_regw", bus.RegWrite, 1'b0);
    end
    next_cyc; at_mid;
    chk("sw_fetch_irw", bus.IRWrite, 1'b1);

    // Branches
    br_case("beq_taken", 3'b000, 1'b1, 1'b1);
    br_case("beq_not",   3'b000, 1'b0, 1'b0);
    br_case("bne_taken", 3'b001, 1'b0, 1'b1);
    br_case("bne_not",   3'b001, 1'b1, 1'b0);

    // ALU decode sweep
    alu_case("alu_r_sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
    alu_case("alu_i_add",  7'b0010011, 3'b000, 1'b1, 3'b000);
    alu_case("alu_r_add",  7'b0110011, 3'b000, 1'b0, 3'b000);
    alu_case("alu_slt",    7'b0110011, 3'b010, 1'b0, 3'b101);
    alu_case("alu_or",     7'b0010011, 3'b110, 1'b0, 3'b011);
    alu_case("alu_and",    7'b0110011, 3'b111, 1'b0, 3'b010);
    alu_case("alu_other",  7'b0110011, 3'b100, 1'b0, 3'b000);

    // jal
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    #1 chk("jal_imm", bus.ImmSrc, 2'b11);
    next_cyc; at_mid;
    next_cyc; at_mid;
    chk("jal_pcw",  bus.PCWrite, 1'b1);
    chk("jal_srca", bus.ALUSrcA, 2'b01);
    next_cyc; at_mid;
    chk("jal_wb_regw", bus.RegWrite, 1'b1);
    next_cyc; at_mid;

    // Reset asserted in the middle of MEMWRITE
    set_in(7'b0100011, 3'b000, 1'b0, 1'b0);
    next_cyc; at_mid;
    next_cyc; at_mid;
    next_cyc;
    reset = 1'b0;
    at_mid;
    chk("rstmw_memw", bus.MemWrite, 1'b0);
    chk("rstmw_regw", bus.RegWrite, 1'b0);
    chk("rstmw_srcb", bus.ALUSrcB,  2'b10);
    next_cyc;
    reset = 1'b1;
    at_mid;
    chk("rstmw_fetch_irw", bus.IRWrite, 1'b1);
    chk("rstmw_fetch_pcw", bus.PCWrite, 1'b1);
    next_cyc; at_mid;
    chk("rstmw_decode_srca", bus.ALUSrcA, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter BNE_EN, default 1, meaning: 1 = funct3 001 branches on !Zero (bne); 0 = funct3 ignored, beq only.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-low reset; reset==0 sampled at a rising clk edge resets the block.
REQ-004 Ports op, funct3, funct7b5, Zero: inputs, widths 7/3/1/1; op, funct3 and funct7b5 are instruction fields from the instruction register; Zero is the ALU zero flag.
REQ-005 Ports PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite: outputs, 1 bit each; PC enable, memory address select (0=PC, 1=Result), IR enable, memory write, register-file write.
REQ-006 Ports ResultSrc, ALUSrcA, ALUSrcB, ImmSrc: outputs, 2 bits each.
REQ-006a Encodings: ResultSrc 00=ALUOut, 01=Data, 10=ALUResult. ALUSrcA 00=PC, 01=OldPC, 10=rd1. ALUSrcB 00=rd2, 01=ImmExt, 10=constant 4.
REQ-007 Port ALUControl, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-008 Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-009 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; next state DECODE.
REQ-010 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH, with no write enable asserted.
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-012 MEMREAD: ResultSrc=00, AdrSrc=1; next state MEMWB.
REQ-012a MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-013 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next state FETCH.
REQ-014 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-014a EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
REQ-014b ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-015 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next state ALUWB.
REQ-016 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next state FETCH.
REQ-017 Any field not listed for a state SHALL be 0 (enables) or 00 (selects).
REQ-018 PCWrite = PCUpdate | (Branch & take), combinational. take = Zero, except take = !Zero when BNE_EN=1 and funct3=001.
REQ-019 Instruction latency in cycles including FETCH: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq/bne 3, unknown op 2.
REQ-020 ImmSrc is combinational from op: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; other -> 00.
REQ-021 ALU decode from ALUOp: 00 -> add; 01 -> sub.
REQ-021a ALU decode for ALUOp=10, by funct3: 000 -> sub when op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-022 Outputs are glitch-free functions of the state register plus the current op/funct3/funct7b5/Zero inputs; the block has no other internal storage.

Reset
REQ-023 reset==0 at a rising edge SHALL load state FETCH, from any state, including mid-instruction; the interrupted instruction is abandoned.
REQ-024 While reset==0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally; select outputs take their FETCH values.
REQ-025 In the first cycle after reset returns to 1, outputs SHALL equal the FETCH values.

Structure
REQ-026 A shared package riscv_pkg SHALL hold: the state enum; opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH); ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
REQ-027 The ALU decode SHALL be a separate sub-module, alu_decoder, with inputs ALUOp, funct3, op5, funct7b5 and output ALUControl. The FSM, ImmSrc decode and PCWrite logic stay in multicycle_controller.

Verification
REQ-028 Reset test: hold reset=0 for 2 cycles with op=0000011. Required: all write enables 0. Release reset; next cycle: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
REQ-029 lw test: op=0000011, funct3=010. Required state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5, with ResultSrc=01; MemWrite stays 0.
REQ-030 sw test: op=0100011. Required: ImmSrc=01; MemWrite=1 and AdrSrc=1 exactly in cycle 4; FETCH in cycle 5; RegWrite never asserted.
REQ-031 beq test: op=1100011, funct3=000, Zero=1 -> cycle 3 PCWrite=1, ALUControl=001, ImmSrc=10. With Zero=0 -> PCWrite=0. With funct3=001 and Zero=0 -> PCWrite=1 (BNE_EN=1).
REQ-032 ALU decode sweep, ALUControl in EXECUTER/EXECUTEI:
- op=0110011, funct3=000, funct7b5=1 -> 001.
- op=0010011, funct3=000, funct7b5=1 -> 000.
- funct3=010 -> 101; 110 -> 011; 111 -> 010.
REQ-033 Boundary test, part 1: op=0000000 -> FETCH, DECODE, FETCH, with no write enable asserted.
REQ-033a Boundary test, part 2: reset=0 asserted during MEMWRITE -> MemWrite=0 in that cycle and FETCH in the next cycle.
